// File: rtl/stopwatch_control.sv
// stopwatch_control: start/pause/clear FSM and BCD MM:SS.hh time accumulator for the stopwatch.
// Optional lap-freeze of the displayed value is built when STOPWATCH_LAP_EN is defined.
module stopwatch_control #(
  parameter int MINUTE_LIMIT = 60
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       start_stop,
  input  logic       clear_req,
  input  logic       lap,
  input  logic       elapsed_10ms,
  output logic       timer_enabled,
  output logic       timer_clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] hund_tens,
  output logic [3:0] hund_ones,
  output logic       running,
  output logic       lap_frozen,
  output logic       overflow
);
  localparam logic [3:0] MT_MAX = 4'((MINUTE_LIMIT - 1) / 10);
  localparam logic [3:0] MO_MAX = 4'((MINUTE_LIMIT - 1) % 10);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_mt, r_mo, r_st, r_so, r_ht, r_ho;
  logic [3:0] w_mt_n, w_mo_n, w_st_n, w_so_n, w_ht_n, w_ho_n;
  logic [23:0] w_live, w_live_n;
  logic w_tick, w_clr, w_c0, w_c1, w_c2, w_c3, w_c4;
  logic r_tclr, r_ovf;

  always_ff @(posedge clk or negedge async_nreset)
    if (!async_nreset) r_state <= IDLE;
    else r_state <= w_next;

  // In RUN start_stop wins over clear; in PAUSE clear wins over start_stop.
  always_comb
    w_next = (r_state == IDLE  && start_stop) ? RUN   :
             (r_state == RUN   && start_stop) ? PAUSE :
             (r_state == PAUSE && clear_req)  ? IDLE  :
             (r_state == PAUSE && start_stop) ? RUN   : r_state;

  always_comb begin
    timer_enabled = r_state == RUN;
    running = r_state == RUN;
    timer_clear = r_tclr;
    overflow = r_ovf;
    w_tick = elapsed_10ms && r_state == RUN;
    w_clr = clear_req && r_state != RUN;
    w_c0 = w_tick && r_ho == 4'd9;
    w_c1 = w_c0 && r_ht == 4'd9;
    w_c2 = w_c1 && r_so == 4'd9;
    w_c3 = w_c2 && r_st == 4'd5;
    w_c4 = w_c3 && r_mt == MT_MAX && r_mo == MO_MAX;
    w_ho_n = !w_tick ? r_ho : w_c0 ? 4'd0 : r_ho + 4'd1;
    w_ht_n = !w_c0 ? r_ht : w_c1 ? 4'd0 : r_ht + 4'd1;
    w_so_n = !w_c1 ? r_so : w_c2 ? 4'd0 : r_so + 4'd1;
    w_st_n = !w_c2 ? r_st : w_c3 ? 4'd0 : r_st + 4'd1;
    w_mo_n = !w_c3 ? r_mo : (w_c4 || r_mo == 4'd9) ? 4'd0 : r_mo + 4'd1;
    w_mt_n = !w_c3 ? r_mt : w_c4 ? 4'd0 : r_mo == 4'd9 ? r_mt + 4'd1 : r_mt;
    w_live = {r_mt, r_mo, r_st, r_so, r_ht, r_ho};
    w_live_n = {w_mt_n, w_mo_n, w_st_n, w_so_n, w_ht_n, w_ho_n};
  end

  always_ff @(posedge clk or negedge async_nreset)
    if (!async_nreset) begin
      {r_mt, r_mo, r_st, r_so, r_ht, r_ho} <= '0;
      r_tclr <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      {r_mt, r_mo, r_st, r_so, r_ht, r_ho} <= w_clr ? 24'd0 : w_live_n;
      r_tclr <= w_clr;
      r_ovf <= w_clr ? 1'b0 : r_ovf | w_c4;
    end

`ifdef STOPWATCH_LAP_EN
  logic r_frz, w_lap_set, w_lap_rel;
  logic [23:0] r_snap;
  always_comb begin
    w_lap_set = lap && !r_frz && r_state == RUN;
    w_lap_rel = lap && r_frz && r_state != IDLE;
    lap_frozen = r_frz;
    {min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones} = r_frz ? r_snap : w_live;
  end

  // Snapshot captures the post-tick value when a tick coincides with lap.
  always_ff @(posedge clk or negedge async_nreset)
    if (!async_nreset) begin
      r_frz <= 1'b0;
      r_snap <= '0;
    end else begin
      r_frz <= w_clr ? 1'b0 : w_lap_set ? 1'b1 : w_lap_rel ? 1'b0 : r_frz;
      if (w_lap_set) r_snap <= w_live_n;
    end
`else
  logic w_unused;
  always_comb begin
    w_unused = lap;
    lap_frozen = 1'b0;
    {min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones} = w_live;
  end
`endif
endmodule
